ram_fifo_ctrl: RTL
==================

Name: ram_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences the team's dual-port RAM (Ram_2Port) as a circular buffer. It owns the write and read pointers, the occupancy count, and the full/empty/threshold flags. It drives the RAM's write-address/write-enable and read-address/read-enable ports directly. Write data goes from the producer straight to the RAM; read data comes from the RAM straight to the consumer, qualified by this block's o_Rd_DV.

Parameters:
DEPTH, 256, number of RAM entries; power of two, >= 4
AF_LEVEL, DEPTH-4, almost-full threshold (count >= AF_LEVEL)
AE_LEVEL, 4, almost-empty threshold (count <= AE_LEVEL)

Ports:
i_Clk  in  1  sole clock; RAM read and write clocks tie to it
i_Rst  in  1  synchronous, active-high reset
i_Flush  in  1  synchronous clear of FIFO contents
i_Wr_DV  in  1  producer write request
i_Rd_En  in  1  consumer read request
o_Ram_Wr_Addr  out  $clog2(DEPTH)  to RAM i_Write_Addr
o_Ram_Wr_DV  out  1  to RAM i_Write_DV
o_Ram_Rd_Addr  out  $clog2(DEPTH)  to RAM i_Read_Addr
o_Ram_Rd_En  out  1  to RAM i_Read_En
o_Rd_DV  out  1  RAM read data valid (registered)
o_Count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
o_Full  out  1  count == DEPTH
o_Empty  out  1  count == 0
o_Almost_Full  out  1  count >= AF_LEVEL
o_Almost_Empty  out  1  count <= AE_LEVEL
o_Overflow  out  1  sticky: write rejected
o_Underflow  out  1  sticky: read rejected

Behaviour:
- Internal registers: wr_ptr and rd_ptr ($clog2(DEPTH) bits each), count ($clog2(DEPTH)+1 bits), o_Rd_DV, o_Overflow, o_Underflow.
- Reset (i_Rst=1 at a clock edge):
  - Pointers, count, o_Rd_DV, o_Overflow and o_Underflow all become 0.
  - Consequent output values: o_Empty=1, o_Full=0, o_Almost_Empty=1, o_Almost_Full=0.
  - Reset overrides i_Flush and all requests; RAM contents are not cleared.
- Write acceptance is combinational: wr_acc = i_Wr_DV & ~o_Full & ~i_Flush & ~i_Rst.
- Read acceptance is combinational: rd_acc = i_Rd_En & ~o_Empty & ~i_Flush & ~i_Rst.
- The full check uses the registered count only. When full and both requests are asserted, the read is accepted and the write is rejected.
- RAM drive is combinational: o_Ram_Wr_Addr = wr_ptr, o_Ram_Wr_DV = wr_acc, o_Ram_Rd_Addr = rd_ptr, o_Ram_Rd_En = rd_acc.
- Pointer update: on wr_acc, wr_ptr increments; on rd_acc, rd_ptr increments. Both wrap DEPTH-1 -> 0.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither are accepted. Count never leaves 0..DEPTH.
- Read latency: o_Rd_DV is rd_acc registered, i.e. high exactly 1 cycle after the accepted read. That is the same edge on which the RAM presents the data.
- Flags are decoded from the registered count and update the cycle after the causing edge.
- Overflow/underflow:
  - o_Overflow sets the cycle after i_Wr_DV=1 with o_Full=1, unless i_Flush is also high.
  - o_Underflow sets the cycle after i_Rd_En=1 with o_Empty=1, unless i_Flush is also high.
  - Both stay set until reset or flush.
- Flush (i_Flush=1):
  - Same-cycle requests are ignored; no RAM enable is asserted.
  - Pointers, count, o_Overflow and o_Underflow become 0.
  - o_Rd_DV becomes 0 on the following edge, even if a read was accepted the cycle before the flush.
- Simultaneous read and write while empty: the write is accepted, the read is rejected and o_Underflow sets. Data is never bypassed.
- Write and read addresses never collide on a accepted same-cycle pair except when count==0, where the read is rejected. The RAM's read-during-write behaviour is therefore irrelevant.
- Expected RTL size: roughly 150–200 lines.

Test Plan:
- Reset then idle (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2) -> o_Empty=1, o_Count=0, o_Almost_Empty=1, no RAM enables, o_Rd_DV=0.
- 8 back-to-back writes, then a 9th -> o_Ram_Wr_Addr steps 0..7; o_Full=1 after the 8th; o_Almost_Full=1 once count reaches 6; the 9th gives o_Ram_Wr_DV=0 and o_Overflow=1 next cycle; o_Count stays 8.
- Read 8 entries with i_Rd_En held high -> o_Ram_Rd_Addr steps 0..7; o_Rd_DV is high for 8 cycles, lagging by 1; o_Empty=1 after the last read; a 9th read sets o_Underflow.
- Count=3, then i_Wr_DV and i_Rd_En together for 20 cycles -> count stays 3; both pointers wrap 7->0 twice with no flag change; also check the full+both case: read accepted, write rejected, count 8->7.
- Count=5, o_Overflow=1, assert i_Flush together with i_Wr_DV and i_Rd_En -> no RAM enables that cycle; next cycle count=0, o_Empty=1, o_Overflow=0, both pointers 0.
- i_Rst pulsed mid-stream, one cycle after an accepted read -> o_Rd_DV=0 on the following edge; all state is at reset values; a subsequent write lands at address 0.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that runs a dual-port RAM as a circular buffer.
// Owns the pointers, the occupancy count, the status flags and the RAM strobes.
module ram_fifo_ctrl #(
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Flush,
    input  logic                     i_Wr_DV,
    input  logic                     i_Rd_En,
    output logic [$clog2(DEPTH)-1:0] o_Ram_Wr_Addr,
    output logic                     o_Ram_Wr_DV,
    output logic [$clog2(DEPTH)-1:0] o_Ram_Rd_Addr,
    output logic                     o_Ram_Rd_En,
    output logic                     o_Rd_DV,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic                     o_Almost_Full,
    output logic                     o_Almost_Empty,
    output logic                     o_Overflow,
    output logic                     o_Underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

    logic [AW-1:0] r_Wr_Ptr;
    logic [AW-1:0] r_Rd_Ptr;
    logic [CW-1:0] r_Count;
    logic          r_Rd_DV;
    logic          r_Overflow;
    logic          r_Underflow;

    logic w_Full;
    logic w_Empty;
    logic w_Wr_Acc;
    logic w_Rd_Acc;

    // Flags come from the registered count only, so a full FIFO rejects a
    // write even when a read drains an entry in the same cycle.
    assign w_Full   = (r_Count == C_DEPTH);
    assign w_Empty  = (r_Count == '0);
    assign w_Wr_Acc = i_Wr_DV & ~w_Full  & ~i_Flush & ~i_Rst;
    assign w_Rd_Acc = i_Rd_En & ~w_Empty & ~i_Flush & ~i_Rst;

    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Flush) begin
            r_Wr_Ptr    <= '0;
            r_Rd_Ptr    <= '0;
            r_Count     <= '0;
            r_Rd_DV     <= 1'b0;
            r_Overflow  <= 1'b0;
            r_Underflow <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural rollover.
            if (w_Wr_Acc) r_Wr_Ptr <= r_Wr_Ptr + AW'(1);
            if (w_Rd_Acc) r_Rd_Ptr <= r_Rd_Ptr + AW'(1);
            case ({w_Wr_Acc, w_Rd_Acc})
                2'b10:   r_Count <= r_Count + CW'(1);
                2'b01:   r_Count <= r_Count - CW'(1);
                default: r_Count <= r_Count;
            endcase
            r_Rd_DV     <= w_Rd_Acc;
            r_Overflow  <= r_Overflow  | (i_Wr_DV & w_Full);
            r_Underflow <= r_Underflow | (i_Rd_En & w_Empty);
        end
    end

    assign o_Ram_Wr_Addr  = r_Wr_Ptr;
    assign o_Ram_Wr_DV    = w_Wr_Acc;
    assign o_Ram_Rd_Addr  = r_Rd_Ptr;
    assign o_Ram_Rd_En    = w_Rd_Acc;
    assign o_Rd_DV        = r_Rd_DV;
    assign o_Count        = r_Count;
    assign o_Full         = w_Full;
    assign o_Empty        = w_Empty;
    assign o_Almost_Full  = (r_Count >= C_AF);
    assign o_Almost_Empty = (r_Count <= C_AE);
    assign o_Overflow     = r_Overflow;
    assign o_Underflow    = r_Underflow;

endmodule
